// File: rtl/usb_tx_retry_fifo.sv
// Purpose : USB IN-endpoint TX FIFO; packet commit on write side, ACK-release / NAK-rewind on read side.
// Latency : 1 cycle from accepted rd_en to rd_data/rd_valid; a commit is visible to the reader next cycle.
// Backpres: writer sees full/afull (space held until ACK), a write while full is dropped and flagged on wr_err;
//           reader sees empty (committed-but-unread words only).
//
// Ports:
//   CLK, RSTn                  clock, asynchronous active-low reset
//   wr_en, wr_data             write one word (dropped when full)
//   wr_commit, wr_abort        expose / discard the words written since the last commit
//   rd_en                      read one committed word (ignored when empty or during tx_nak)
//   rd_data, rd_valid          registered read data, valid the cycle after an accepted rd_en
//   tx_ack, tx_nak             release words read so far / rewind reads to the release point
//   wr_level, rd_avail         occupied entries (wp - rel), committed unread words (wc - rp)
//   full, afull, empty, wr_err status flags, wr_err is a one-cycle pulse
module usb_tx_retry_fifo #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 9,
    parameter int AFULL_LVL = 448
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             wr_commit,
    input  logic             wr_abort,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    input  logic             tx_ack,
    input  logic             tx_nak,
    output logic [ASIZE:0]   wr_level,
    output logic [ASIZE:0]   rd_avail,
    output logic             full,
    output logic             afull,
    output logic             empty,
    output logic             wr_err
);

    localparam int             DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_LVL  = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] AFULL_THR = (ASIZE+1)'(AFULL_LVL);

    // Pointers carry one extra MSB so wp - rel distinguishes full from empty.
    logic [ASIZE:0]   r_wp;
    logic [ASIZE:0]   r_wc;
    logic [ASIZE:0]   r_rp;
    logic [ASIZE:0]   r_rel;

    logic [DSIZE-1:0] r_mem [0:DEPTH-1];
    logic [DSIZE-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_wr_err;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [ASIZE:0]   w_wr_level;
    logic [ASIZE:0]   w_rd_avail;
    logic [ASIZE:0]   w_wp_after_wr;

    // Status from registered pointers only. Space is counted from rel, not rp,
    // so words awaiting an ACK keep their slots until the host confirms them.
    assign w_wr_level = r_wp - r_rel;
    assign w_rd_avail = r_wc - r_rp;
    assign w_full     = (w_wr_level == FULL_LVL);
    assign w_empty    = (w_rd_avail == '0);

    // An abort discards the whole uncommitted packet, including this cycle's word.
    assign w_wr_acc      = wr_en & ~w_full & ~wr_abort;
    assign w_wp_after_wr = r_wp + {{ASIZE{1'b0}}, w_wr_acc};

    // A NAK takes the read port for the cycle so the rewind is never mixed with a fetch.
    assign w_rd_acc = rd_en & ~w_empty & ~tx_nak;

    // Storage is not reset.
    always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
            r_mem[r_wp[ASIZE-1:0]] <= wr_data;
        end
    end

    // Write side: abort wins over commit; commit includes a same-cycle accepted word.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wp     <= '0;
            r_wc     <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en & w_full;
            if (wr_abort) begin
                r_wp <= r_wc;
            end else begin
                r_wp <= w_wp_after_wr;
                if (wr_commit) begin
                    r_wc <= w_wp_after_wr;
                end
            end
        end
    end

    // Read side: NAK rewinds to the release point and wins over ACK;
    // ACK releases everything read before this cycle's fetch.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rp       <= '0;
            r_rel      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (tx_nak) begin
                r_rp <= r_rel;
            end else begin
                if (tx_ack) begin
                    r_rel <= r_rp;
                end
                if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_rp[ASIZE-1:0]];
                    r_rp      <= r_rp + 1'b1;
                end
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign wr_err   = r_wr_err;
    assign wr_level = w_wr_level;
    assign rd_avail = w_rd_avail;
    assign full     = w_full;
    assign afull    = (w_wr_level >= AFULL_THR);
    assign empty    = w_empty;

endmodule

// File: tb/tb_usb_tx_retry_fifo.sv
// Purpose : exercise usb_tx_retry_fifo (DSIZE=8, ASIZE=4, AFULL_LVL=12) against an unbounded-index packet model.
// Latency : checks every cycle, 1 time unit after the rising edge.
// Backpres: drives full/empty corner cases; the model decides what is dropped.
module tb_usb_tx_retry_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          wr_en, wr_commit, wr_abort, rd_en, tx_ack, tx_nak;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, afull, empty, wr_err;
    logic [AW:0]   wr_level, rd_avail;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: absolute (never-wrapping) word indices; data held by absolute index.
    int            m_wp, m_wc, m_rp, m_rel;
    logic [DW-1:0] m_mem [int];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid, m_wr_err;

    usb_tx_retry_fifo #(.DSIZE(DW), .ASIZE(AW), .AFULL_LVL(AFL)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit), .wr_abort(wr_abort),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .tx_ack(tx_ack), .tx_nak(tx_nak),
        .wr_level(wr_level), .rd_avail(rd_avail),
        .full(full), .afull(afull), .empty(empty), .wr_err(wr_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wp = 0; m_wc = 0; m_rp = 0; m_rel = 0;
        m_rd_data = '0; m_rd_valid = 1'b0; m_wr_err = 1'b0;
    endtask

    // Next state from the rules: space counted from the released index, reads from committed words.
    task automatic model_update();
        bit m_full;
        bit m_empty;
        m_full   = ((m_wp - m_rel) == DEPTH);
        m_empty  = (m_wc == m_rp);
        m_wr_err = wr_en && m_full;
        if (wr_abort) begin
            m_wp = m_wc;
        end else begin
            if (wr_en && !m_full) begin
                m_mem[m_wp] = wr_data;
                m_wp++;
            end
            if (wr_commit) m_wc = m_wp;
        end
        if (tx_nak) begin
            m_rp = m_rel;
            m_rd_valid = 1'b0;
        end else begin
            if (tx_ack) m_rel = m_rp;
            if (rd_en && !m_empty) begin
                m_rd_data  = m_mem[m_rp];
                m_rp++;
                m_rd_valid = 1'b1;
            end else begin
                m_rd_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        int lvl;
        lvl = m_wp - m_rel;
        chk("rd_valid", rd_valid, m_rd_valid);
        chk("rd_data",  rd_data,  m_rd_data);
        chk("wr_err",   wr_err,   m_wr_err);
        chk("wr_level", wr_level, lvl);
        chk("rd_avail", rd_avail, m_wc - m_rp);
        chk("full",     full,     lvl == DEPTH);
        chk("afull",    afull,    lvl >= AFL);
        chk("empty",    empty,    m_wc == m_rp);
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic cm, input logic ab,
                       input logic re, input logic ak, input logic nk);
        wr_en = we; wr_data = wd; wr_commit = cm; wr_abort = ab;
        rd_en = re; tx_ack = ak; tx_nak = nk;
        model_update();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RSTn = 1'b0;
        wr_en = 0; wr_data = '0; wr_commit = 0; wr_abort = 0;
        rd_en = 0; tx_ack = 0; tx_nak = 0;
        model_reset();
        #8;
        chk("rst_empty", empty, 1'b1);
        chk("rst_level", wr_level, 0);
        chk("rst_valid", rd_valid, 1'b0);
        #4 RSTn = 1'b1;
        idle();

        // Uncommitted words occupy space but are not readable.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_level4", wr_level, 4);
        chk("lit_avail0", rd_avail, 0);
        chk("lit_empty1", empty, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_avail4", rd_avail, 4);
        chk("lit_empty0", empty, 1'b0);

        // Back-to-back read, rewind, re-read, release.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("lit_rd1", rd_data, 8'h11 + 8'(i));
            chk("lit_vld1", rd_valid, 1'b1);
        end
        idle();
        chk("lit_vld_off", rd_valid, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_nak_avail", rd_avail, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("lit_rd2", rd_data, 8'h11 + 8'(i));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_ack_level", wr_level, 0);

        // Abort discards the packet, including a same-cycle write.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h24, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_abort_level", wr_level, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_abort_avail", rd_avail, 0);

        // Fill to full, overflow, read without ACK, then release.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'h30 + 8'(i), (i == 15), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 10) chk("lit_afull0", afull, 1'b0);
            if (i == 11) chk("lit_afull1", afull, 1'b1);
        end
        chk("lit_full", full, 1'b1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_wr_err", wr_err, 1'b1);
        chk("lit_full_lvl", wr_level, 16);
        idle();
        chk("lit_wr_err_off", wr_err, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("lit_rd_full", rd_data, 8'h30 + 8'(i));
        end
        chk("lit_full_noack", full, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_full_ack", full, 1'b0);

        // Wrap: many short packets across pointer MSB toggles.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 7; i++) cyc(1'b1, 8'(r * 7 + i + 3), (i == 6), 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // NAK + ACK + rd_en together with five words outstanding.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h50 + 8'(i), (i == 7), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit_pre_nak_avail", rd_avail, 3);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("lit_nak_vld", rd_valid, 1'b0);
        chk("lit_nak_rp", rd_avail, 8);
        chk("lit_nak_rel", wr_level, 8);

        // Asynchronous reset in the middle of a packet.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wr_en = 0; rd_en = 0;
        #2 RSTn = 1'b0;
        #1;
        model_reset();
        chk("arst_rd_data", rd_data, 8'h00);
        chk("arst_level", wr_level, 0);
        chk("arst_avail", rd_avail, 0);
        chk("arst_empty", empty, 1'b1);
        compare_all();
        #3 RSTn = 1'b1;
        idle();
        cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit_post_rst", rd_data, 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_tx_retry_fifo.md
Name: usb_tx_retry_fifo

Overview:
Parametrised synchronous TX FIFO for USB IN endpoints with packet-level commit on the write side and acknowledge/rewind on the read side. Written data becomes readable only after the writer commits the packet. Consumed data is freed only after the host ACKs it. A NAK or timeout rewinds reads to the last ACKed byte so the packet is retransmitted. It sits between the audio/packetiser write logic and the USB device controller TX data port.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 9, address width; depth = 2^ASIZE entries
AFULL_LVL, 448, almost-full threshold in entries (1..2^ASIZE)

Ports:
CLK  in  1  clock
RSTn  in  1  reset; asynchronous, active-low
wr_en  in  1  write one word (ignored when full)
wr_data  in  DSIZE  write data
wr_commit  in  1  make all written words, including any written this cycle, visible to reader
wr_abort  in  1  discard uncommitted words
rd_en  in  1  read request (ignored when empty)
rd_data  out  DSIZE  registered read data
rd_valid  out  1  rd_data holds the word requested last cycle
tx_ack  in  1  pulse: words read so far are released
tx_nak  in  1  pulse: rewind read pointer to release pointer
wr_level  out  ASIZE+1  occupied entries = wp - rel
rd_avail  out  ASIZE+1  committed unread words = wc - rp
full  out  1  wr_level == 2^ASIZE
afull  out  1  wr_level >= AFULL_LVL
empty  out  1  rd_avail == 0
wr_err  out  1  one-cycle pulse: wr_en while full

Behaviour:
- Pointers: wp (write), wc (commit), rp (read), rel (release). All ASIZE+1 bits, modulo 2^(ASIZE+1). Invariant: rel <= rp <= wc <= wp, measured modulo.
- Reset (async): all pointers 0; rd_data 0, rd_valid 0, wr_err 0. Hence empty=1, full=0, afull=0, wr_level=0, rd_avail=0. RAM contents are not reset.
- Write: wr_en & ~full stores wr_data at RAM[wp[ASIZE-1:0]], then wp+1. wr_en & full drops the word, leaves wp unchanged, and pulses wr_err next cycle.
- wr_commit: wc <= wp after this cycle's write (includes a same-cycle accepted write).
- wr_abort: wp <= wc; a same-cycle wr_en is ignored. abort has priority over commit when both are asserted.
- Read: rd_en & ~empty & ~tx_nak captures RAM[rp] into rd_data and increments rp. rd_valid=1 in the next cycle; otherwise rd_valid=0 and rd_data holds its value. Latency is 1 cycle. Back-to-back reads run at 1 word/cycle.
- tx_ack: rel <= rp (value before any same-cycle increment). A same-cycle read still proceeds.
- tx_nak: rp <= rel. A same-cycle rd_en is ignored and rd_valid=0 next cycle. tx_nak has priority over tx_ack when both are asserted; rel is unchanged.
- Status flags are combinational from the registered pointers. full uses rel, not rp, so unacknowledged data still occupies space. afull compares wr_level against AFULL_LVL.
- Wrap-around: the MSB distinguishes full (wp-rel = 2^ASIZE) from empty. All subtractions are ASIZE+1 bits, unsigned modulo.
- Simultaneous write and release when full: full is evaluated on pre-cycle pointers, so a write in the same cycle as tx_ack is dropped.
- rd_en while empty: no pointer change and no wr_err; rd_valid=0.

Test Plan:
- Reset, then write 4 words 0x11..0x14 without commit -> wr_level=4, rd_avail=0, empty=1. Assert wr_commit -> rd_avail=4, empty=0 next cycle.
- Read 4 words with back-to-back rd_en -> rd_data 0x11,0x12,0x13,0x14 each one cycle after its rd_en, rd_valid high 4 cycles. Then tx_nak -> rd_avail=4. Re-read returns 0x11..0x14. Then tx_ack -> wr_level=0.
- Write 3 words, wr_abort together with a 4th wr_en -> wp back to wc, wr_level unchanged. A subsequent commit exposes 0 new words.
- ASIZE=4: fill 16 words -> full=1, afull=1 (AFULL_LVL=12 from 12 words). A 17th write pulses wr_err=1 and the word is lost. Read all 16 without ack -> full stays 1. tx_ack -> full=0.
- Wrap: cycle 40 commit/read/ack rounds of 7 words on depth 16 -> data order intact and flags correct across pointer MSB toggles.
- Same cycle tx_nak+tx_ack+rd_en with rp=rel+5 -> rp=rel, rel unchanged, rd_valid=0 next cycle. Assert RSTn low mid-packet -> all outputs return to reset values immediately.
